// File: rtl/video_timing_gen.sv
// Raster timing generator: registered hsync/vsync, draw area, coordinates and line/frame strobes.
// Define VIDEO_TIMING_TEST_PATTERN_EN to build the 8-bar colour pattern on rgb_o (otherwise rgb_o is 0).
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          pixel_clk_i,
  input  logic          rstn_i,
  input  logic          en_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          draw_area_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic [23:0]   rgb_o
);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("video_timing_gen: every timing parameter must be non-zero");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          draw;
  logic          hs_act;
  logic          vs_act;
  logic          h_last;
  logic          v_last;

  assign draw   = (h < H_ACT_END) && (v < V_ACT_END);
  assign hs_act = (h >= HS_START) && (h < HS_END);
  assign vs_act = (v >= VS_START) && (v < VS_END);
  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  // Outputs describe the position held before this edge; en_i low parks everything at origin.
  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h             <= '0;
      v             <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      draw_area_o   <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (!en_i) begin
      h             <= '0;
      v             <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      draw_area_o   <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      hsync_o       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_o       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      draw_area_o   <= draw;
      x_o           <= h;
      y_o           <= v;
      line_start_o  <= (h == '0);
      frame_start_o <= (h == '0) && (v == '0);
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  if (H_ACTIVE % 8 != 0) begin : g_bad_bars
    $error("video_timing_gen: H_ACTIVE must be a multiple of 8 for the colour bars");
  end

  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;

  assign bar_idx = 3'(h / BAR_W);

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase
  end

  // Registered alongside the timing outputs so colour stays aligned with x_o.
  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_o <= 24'h0;
    end else if (!en_i) begin
      rgb_o <= 24'h0;
    end else begin
      rgb_o <= draw ? bar_rgb : 24'h0;
    end
  end
`else
  assign rgb_o = 24'h0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen with a shrunken raster and a position-index reference model.
// Honours VIDEO_TIMING_TEST_PATTERN_EN so the expected rgb_o follows the build.
module tb_video_timing_gen;

  localparam int HA    = 64;
  localparam int HFP   = 8;
  localparam int HSW   = 12;
  localparam int HBP   = 12;
  localparam int VA    = 24;
  localparam int VFP   = 3;
  localparam int VSW   = 2;
  localparam int VBP   = 4;
  localparam bit HPOL  = 1'b0;
  localparam bit VPOL  = 1'b1;
  localparam int HT    = HA + HFP + HSW + HBP;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int HW    = $clog2(HT);
  localparam int VW    = $clog2(VT);
  localparam int VECW  = 3 + HW + VW + 2 + 24;

  logic          pixel_clk_i = 1'b0;
  logic          rstn_i;
  logic          en_i;
  logic          hsync_o;
  logic          vsync_o;
  logic          draw_area_o;
  logic [HW-1:0] x_o;
  logic [VW-1:0] y_o;
  logic          line_start_o;
  logic          frame_start_o;
  logic [23:0]   rgb_o;

  int n_vec = 0;
  int n_err = 0;
  int p = 0;
  int last_idx = -1;
  logic [VECW-1:0] exp_vec;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .pixel_clk_i  (pixel_clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .draw_area_o  (draw_area_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .line_start_o (line_start_o),
    .frame_start_o(frame_start_o),
    .rgb_o        (rgb_o)
  );

  always #5 pixel_clk_i = ~pixel_clk_i;

  // Expected outputs for the idx-th pixel of a frame, derived from linear position.
  function automatic logic [VECW-1:0] ref_at(input int idx);
    int x, y;
    logic draw, hs, vs;
    logic [23:0] rgb;
    x    = idx % HT;
    y    = idx / HT;
    draw = (x < HA) && (y < VA);
    hs   = (x >= HA + HFP) && (x < HA + HFP + HSW);
    vs   = (y >= VA + VFP) && (y < VA + VFP + VSW);
    rgb  = 24'h0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    if (draw) rgb = bars[x / (HA / 8)];
`endif
    return {hs ? HPOL : ~HPOL, vs ? VPOL : ~VPOL, draw, HW'(x), VW'(y),
            x == 0, idx == 0, rgb};
  endfunction

  function automatic logic [VECW-1:0] ref_reset();
    return {~HPOL, ~VPOL, 1'b0, HW'(0), VW'(0), 1'b0, 1'b0, 24'h0};
  endfunction

  function automatic logic [23:0] rgb_const(input int x);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    case (x)
      0:       return 24'hFFFFFF;
      8:       return 24'hFFFF00;
      default: return 24'h000000;
    endcase
`else
    return 24'h000000;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [VECW-1:0] expv);
    logic [VECW-1:0] obs;
    obs = {hsync_o, vsync_o, draw_area_o, x_o, y_o, line_start_o, frame_start_o, rgb_o};
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock edge with the given enable, then compare every output against the model.
  task automatic apply_stimulus(input logic en_val, input string tag);
    en_i = en_val;
    @(posedge pixel_clk_i);
    if (!rstn_i || !en_val) begin
      exp_vec  = ref_reset();
      p        = 0;
      last_idx = -1;
    end else begin
      exp_vec  = ref_at(p);
      last_idx = p;
      p        = (p + 1) % FRAME;
    end
    #1;
    check_output(tag, exp_vec);
  endtask

  task automatic walk_to(input int target);
    for (int k = 0; k < FRAME + 1 && last_idx != target; k++) apply_stimulus(1'b1, "walk");
    check_int("walk_reached", last_idx, target);
  endtask

  initial begin
    int fs_prev, fs_count, hs_cnt, vs_cnt;
    rstn_i = 1'b0;
    en_i   = 1'b1;
    $display("[TB] reset held with en_i high");
    repeat (3) apply_stimulus(1'b1, "reset_held");

    rstn_i = 1'b1;
    apply_stimulus(1'b1, "first_edge");
    check_int("first_frame_start", int'(frame_start_o), 1);

    $display("[TB] two full frames");
    fs_prev = 0; fs_count = 1; hs_cnt = 0; vs_cnt = 0;
    if (hsync_o == HPOL) hs_cnt++;
    if (vsync_o == VPOL) vs_cnt++;
    for (int k = 1; k < 2 * FRAME + 1; k++) begin
      apply_stimulus(1'b1, "run");
      if (frame_start_o) begin
        check_int("fs_period", k - fs_prev, FRAME);
        fs_prev = k;
        fs_count++;
      end
      if (k < FRAME) begin
        if (hsync_o == HPOL) hs_cnt++;
        if (vsync_o == VPOL) vs_cnt++;
      end
      if (last_idx == 0 || last_idx == 8 || last_idx == 63 || last_idx == 70)
        check_int($sformatf("rgb_x%0d", last_idx), int'(rgb_o), int'(rgb_const(last_idx)));
    end
    check_int("fs_count", fs_count, 3);
    check_int("hsync_cycles", hs_cnt, HSW * VT);
    check_int("vsync_cycles", vs_cnt, VSW * HT);

    $display("[TB] enable drop mid-line");
    walk_to(10 * HT + 30);
    check_int("pre_drop_x", int'(x_o), 30);
    repeat (5) apply_stimulus(1'b0, "en_low");
    apply_stimulus(1'b1, "reenable");
    check_int("reenable_frame_start", int'(frame_start_o), 1);

    $display("[TB] asynchronous reset mid-frame");
    walk_to(28 * HT + 70);
    #2 rstn_i = 1'b0;
    #1;
    p = 0;
    last_idx = -1;
    check_output("async_rst_immediate", ref_reset());
    repeat (2) apply_stimulus(1'b1, "async_rst_held");
    rstn_i = 1'b1;
    apply_stimulus(1'b1, "async_rst_origin");
    check_int("async_rst_frame_start", int'(frame_start_o), 1);

    $display("[TB] randomized enable and reset");
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(15) != 0, "random");
      if ($urandom_range(299) == 0) begin
        #2 rstn_i = 1'b0;
        #1;
        p = 0;
        last_idx = -1;
        check_output("random_async_rst", ref_reset());
        rstn_i = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
